mem_arbiter: RTL

- Shares one line-granular physical-memory port between the instruction cache (I side) and the data cache (D side) of the pipelined RV32I core.
- A registered-grant FSM selects one requester, latches its address and write data, drives the memory port until mem_resp, then routes the response back to the owner.
- Sits between the L1 caches and physical memory (or L2).

---
 rtl/rv32i_types.sv | 17 +
 rtl/mem_arb_select.sv | 45 ++++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I memory subsystem: arbiter FSM states, port owner, cache line.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } mem_arb_owner_t;

  typedef logic [255:0] rv32i_line;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the I/D memory arbiter. MEM_ARB_ROUND_ROBIN_EN adds a last-owner
// register that breaks simultaneous-request ties in favour of the side not served last.
module mem_arb_select
  import rv32i_types::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic           clk,
  input  logic           rst,
  input  logic           take,
`endif
  input  logic           i_req,
  input  logic           d_req,
  output logic           grant,
  output mem_arb_owner_t owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_arb_owner_t last_owner;

  always_comb begin
    grant = i_req | d_req;
    owner = ARB_OWNER_I;
    if (i_req && d_req) begin
      owner = (last_owner == ARB_OWNER_I) ? ARB_OWNER_D : ARB_OWNER_I;
    end else if (d_req) begin
      owner = ARB_OWNER_D;
    end
  end

  // Only a grant actually taken in IDLE moves the tie-break pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= ARB_OWNER_I;
    end else if (take && grant) begin
      last_owner <= owner;
    end
  end
`else
  always_comb begin
    grant = i_req | d_req;
    owner = d_req ? ARB_OWNER_D : ARB_OWNER_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Registered-grant arbiter sharing one line-granular memory port between I and D caches.
// Optional macro MEM_ARB_ROUND_ROBIN_EN switches tie-breaking from fixed D priority to alternating.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [1:0] ST_IDLE    = ARB_IDLE;
  localparam logic [1:0] ST_SERVE_I = ARB_SERVE_I;
  localparam logic [1:0] ST_SERVE_D = ARB_SERVE_D;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_write;

  logic              d_req;
  logic              grant;
  mem_arb_owner_t    owner;
  logic              own_i;
  logic              own_d;

  assign d_req = d_read | d_write;

  mem_arb_select u_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst   (rst),
    .take  (state == ST_IDLE),
`endif
    .i_req (i_read),
    .d_req (d_req),
    .grant (grant),
    .owner (owner)
  );

  // Latched address/data/op drive memory, so requester changes mid-transaction are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            if (owner == ARB_OWNER_D) begin
              state    <= ST_SERVE_D;
              addr_q   <= d_addr;
              op_write <= d_write;
              if (d_write) begin
                wdata_q <= d_wdata;
              end
            end else begin
              state    <= ST_SERVE_I;
              addr_q   <= i_addr;
              op_write <= 1'b0;
            end
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (mem_resp) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode the registered state only, so an async reset drops them immediately.
  always_comb begin
    own_i     = (state == ST_SERVE_I);
    own_d     = (state == ST_SERVE_D);
    mem_read  = (own_i | own_d) & ~op_write;
    mem_write = (own_i | own_d) & op_write;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_resp    = mem_resp & own_i;
    d_resp    = mem_resp & own_d;
    i_rdata   = own_i ? mem_rdata : '0;
    d_rdata   = own_d ? mem_rdata : '0;
  end

endmodule
